pll_reset_sequencer: RTL and testbench

Reset and lock sequencer sitting directly downstream of the core PLL. It drives the PLL's `rst` input, consumes the asynchronous `locked` output, and produces the core-wide reset only after lock is stable. It retries lock acquisition on timeout, re-sequences on loss of lock, and latches a fault after repeated failures. It runs on the 74.25 MHz reference clock, which is free-running and independent of the PLL.

---
 rtl/pll_reset_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//
// Reset and lock sequencer for the core PLL. Pulses the PLL reset, waits for
// a stable synchronized lock, then releases the core-wide reset. Retries lock
// acquisition on timeout, re-sequences on loss of lock, and latches FAULT
// after MAX_RETRIES consecutive timeouts. Runs on the free-running 74.25 MHz
// reference clock.
//
// Optional feature macro: PLL_RESET_SEQ_STATS_EN
//   defined   : timeout_count / loss_count saturating counters are built
//   undefined : both count ports are tied to 8'd0
//
// Ports:
//   clk_74a         in   reference clock (same source as PLL refclk)
//   reset_n         in   asynchronous active-low reset
//   pll_locked      in   PLL lock, asynchronous (2-flop synchronized)
//   soft_reset_req  in   core reset request, asynchronous (2-flop synchronized)
//   pll_rst         out  PLL reset, active high
//   core_reset_n    out  core reset, active low
//   state           out  0 PLL_RST, 1 WAIT_LOCK, 2 SETTLE, 3 RUN, 4 HOLD, 7 FAULT
//   fault           out  high in FAULT
//   timeout_count   out  total lock timeouts, saturating at 255
//   loss_count      out  lock losses in RUN/HOLD, saturating at 255

module pll_reset_sequencer #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 742500,
  parameter int unsigned SETTLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 4
) (
  input  logic       clk_74a,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       soft_reset_req,
  output logic       pll_rst,
  output logic       core_reset_n,
  output logic [2:0] state,
  output logic       fault,
  output logic [7:0] timeout_count,
  output logic [7:0] loss_count
);

  localparam int unsigned Max01 = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned Max23 = (SETTLE_CYCLES > MAX_RETRIES) ? SETTLE_CYCLES : MAX_RETRIES;
  localparam int unsigned MaxParam = (Max01 > Max23) ? Max01 : Max23;
  localparam int unsigned CntW   = $clog2(MaxParam) + 1;
  localparam int unsigned RetryW = $clog2(MAX_RETRIES) + 1;

  localparam logic [CntW-1:0]   RstLast    = CntW'(RST_CYCLES - 1);
  localparam logic [CntW-1:0]   ToLast     = CntW'(LOCK_TIMEOUT - 1);
  // SETTLE leaves one cycle later than HOLD: the entry cycle plus a full count.
  localparam logic [CntW-1:0]   SettleDone = CntW'(SETTLE_CYCLES);
  localparam logic [CntW-1:0]   HoldLast   = CntW'(SETTLE_CYCLES - 1);
  localparam logic [RetryW-1:0] RetryLast  = RetryW'(MAX_RETRIES - 1);

  typedef enum logic [2:0] {
    StPllRst   = 3'd0,
    StWaitLock = 3'd1,
    StSettle   = 3'd2,
    StRun      = 3'd3,
    StHold     = 3'd4,
    StFault    = 3'd7
  } state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [RetryW-1:0] retry_q;
  logic [1:0]        lock_sync_q;
  logic [1:0]        req_sync_q;
  logic              locked_s;
  logic              req_s;
  logic              timeout_evt;

  assign state = state_q;

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      lock_sync_q <= 2'b00;
      req_sync_q  <= 2'b00;
    end else begin
      lock_sync_q <= {lock_sync_q[0], pll_locked};
      req_sync_q  <= {req_sync_q[0], soft_reset_req};
    end
  end

  assign locked_s = lock_sync_q[1];
  assign req_s    = req_sync_q[1];

  assign timeout_evt = (state_q == StWaitLock) && !locked_s && (cnt_q == ToLast);

  // Outputs are assigned alongside each transition so they change on the same
  // edge as state.
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StPllRst;
      cnt_q        <= '0;
      retry_q      <= '0;
      pll_rst      <= 1'b1;
      core_reset_n <= 1'b0;
      fault        <= 1'b0;
    end else begin
      case (state_q)
        StPllRst: begin
          if (cnt_q == RstLast) begin
            state_q <= StWaitLock;
            cnt_q   <= '0;
            pll_rst <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StWaitLock: begin
          if (locked_s) begin
            state_q <= StSettle;
            cnt_q   <= '0;
          end else if (timeout_evt) begin
            cnt_q   <= '0;
            pll_rst <= 1'b1;
            retry_q <= retry_q + 1'b1;
            if (retry_q == RetryLast) begin
              state_q <= StFault;
              fault   <= 1'b1;
            end else begin
              state_q <= StPllRst;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StSettle: begin
          if (!locked_s) begin
            // Lock dropped before it was stable; restart the lock wait.
            state_q <= StWaitLock;
            cnt_q   <= '0;
          end else if (cnt_q == SettleDone) begin
            state_q      <= StRun;
            cnt_q        <= '0;
            retry_q      <= '0;
            core_reset_n <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StRun: begin
          if (!locked_s) begin
            state_q      <= StPllRst;
            cnt_q        <= '0;
            pll_rst      <= 1'b1;
            core_reset_n <= 1'b0;
          end else if (req_s) begin
            state_q      <= StHold;
            cnt_q        <= '0;
            core_reset_n <= 1'b0;
          end
        end
        StHold: begin
          if (!locked_s) begin
            // Lock loss wins over a pending soft reset request.
            state_q <= StPllRst;
            cnt_q   <= '0;
            pll_rst <= 1'b1;
          end else if (req_s) begin
            cnt_q <= '0;
          end else if (cnt_q == HoldLast) begin
            state_q      <= StRun;
            cnt_q        <= '0;
            core_reset_n <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StFault: begin
          pll_rst      <= 1'b1;
          core_reset_n <= 1'b0;
          fault        <= 1'b1;
        end
        default: begin
          // Unused encodings recover through a fresh PLL reset.
          state_q      <= StPllRst;
          cnt_q        <= '0;
          pll_rst      <= 1'b1;
          core_reset_n <= 1'b0;
          fault        <= 1'b0;
        end
      endcase
    end
  end

`ifdef PLL_RESET_SEQ_STATS_EN
  logic loss_evt;

  assign loss_evt = ((state_q == StRun) || (state_q == StHold)) && !locked_s;

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      timeout_count <= 8'd0;
      loss_count    <= 8'd0;
    end else begin
      if (timeout_evt && (timeout_count != 8'hFF)) begin
        timeout_count <= timeout_count + 8'd1;
      end
      if (loss_evt && (loss_count != 8'hFF)) begin
        loss_count <= loss_count + 8'd1;
      end
    end
  end
`else
  assign timeout_count = 8'd0;
  assign loss_count    = 8'd0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer. Expected edges are computed
// from the timing rules: an input changed after edge k reaches the FSM via the
// synchronizer and moves state at edge k+3; PLL_RST lasts RST_CYCLES edges;
// a timeout fires LOCK_TIMEOUT edges after WAIT_LOCK entry; SETTLE lasts
// SETTLE_CYCLES+1 edges; HOLD releases SETTLE_CYCLES edges after req_s falls.
module tb_pll_reset_sequencer;

  localparam int RstC = 4;
  localparam int ToC  = 100;
  localparam int SetC = 8;
  localparam int MaxR = 3;

  localparam int StPll   = 0;
  localparam int StWait  = 1;
  localparam int StSet   = 2;
  localparam int StRun   = 3;
  localparam int StHold  = 4;
  localparam int StFault = 7;

`ifdef PLL_RESET_SEQ_STATS_EN
  localparam int Stats = 1;
`else
  localparam int Stats = 0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       soft_reset_req = 1'b0;
  logic       pll_rst;
  logic       core_reset_n;
  logic [2:0] state;
  logic       fault;
  logic [7:0] timeout_count;
  logic [7:0] loss_count;

  int checks   = 0;
  int failures = 0;
  int t        = 0;  // rising edges since the last reset release

  pll_reset_sequencer #(
    .RST_CYCLES   (RstC),
    .LOCK_TIMEOUT (ToC),
    .SETTLE_CYCLES(SetC),
    .MAX_RETRIES  (MaxR)
  ) dut (
    .clk_74a       (clk),
    .reset_n       (reset_n),
    .pll_locked    (pll_locked),
    .soft_reset_req(soft_reset_req),
    .pll_rst       (pll_rst),
    .core_reset_n  (core_reset_n),
    .state         (state),
    .fault         (fault),
    .timeout_count (timeout_count),
    .loss_count    (loss_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog t=%0d observed=running expected=finished", t);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s t=%0d observed=%0d expected=%0d", tag, t, obs, exp);
    end
  endtask

  // Output decode follows directly from the state.
  task automatic chk_st(input string tag, input int st);
    chk({tag, ".state"}, state, st);
    chk({tag, ".pll_rst"}, pll_rst, (st == StPll || st == StFault) ? 1 : 0);
    chk({tag, ".core_reset_n"}, core_reset_n, (st == StRun) ? 1 : 0);
    chk({tag, ".fault"}, fault, (st == StFault) ? 1 : 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic go(input int e);
    while (t < e) tick();
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk);
    #1;
    reset_n        = 1'b0;
    pll_locked     = 1'b0;
    soft_reset_req = 1'b0;
    #1;
    chk_st({tag, ".rst"}, StPll);
    chk({tag, ".rst.tc"}, timeout_count, 0);
    chk({tag, ".rst.lc"}, loss_count, 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    t = 0;
  endtask

  initial begin
    int k, d, g, re, e0, m, s, l, s2, st;

    // Clean bring-up with lock raised before edge 20.
    do_reset("up");
    go(3);  chk_st("up3", StPll);
    go(4);  chk_st("up4", StWait);
    go(19); pll_locked = 1'b1;
    go(21); chk_st("up21", StWait);
    go(22); chk_st("up22", StSet);
    go(30); chk_st("up30", StSet);
    go(31); chk_st("up31", StRun);

    // Lock glitch during SETTLE.
    do_reset("gl");
    k = $urandom_range(5, 40);
    go(k); pll_locked = 1'b1;
    go(k + 3); chk_st("gl.settle", StSet);
    d = k + 3 + $urandom_range(0, 5);
    g = $urandom_range(1, 5);
    go(d); pll_locked = 1'b0;
    for (int e = d + 1; e <= d + g + 3; e++) begin
      go(e);
      if (e == d + g) pll_locked = 1'b1;
      if (e == d + 3) begin
        chk_st("gl.wait", StWait);
        chk("gl.tc", timeout_count, 0);
      end
    end
    re = d + g + 3;
    chk_st("gl.resettle", StSet);
    go(re + 8); chk_st("gl.pre_run", StSet);
    go(re + 9); chk_st("gl.run", StRun);
    chk("gl.tc_end", timeout_count, 0);

    // Lock loss in RUN and full re-sequence.
    e0 = re + 9 + $urandom_range(1, 10);
    go(e0); pll_locked = 1'b0;
    go(e0 + 2); chk_st("ll.still_run", StRun);
    go(e0 + 3); chk_st("ll.pllrst", StPll);
    chk("ll.lc", loss_count, Stats);
    go(e0 + 6); chk_st("ll.pllrst_end", StPll);
    go(e0 + 7); chk_st("ll.wait", StWait);
    m = $urandom_range(0, 20);
    go(e0 + 7 + m); pll_locked = 1'b1;
    go(e0 + 9 + m);  chk_st("ll.wait_end", StWait);
    go(e0 + 10 + m); chk_st("ll.settle", StSet);
    go(e0 + 19 + m); chk_st("ll.run", StRun);

    // Soft reset request while in RUN.
    s = t + $urandom_range(1, 5);
    l = $urandom_range(1, 12);
    go(s); soft_reset_req = 1'b1;
    for (int e = s + 1; e <= s + l + 10; e++) begin
      go(e);
      if (e == s + l) soft_reset_req = 1'b0;
      st = (e < s + 3 || e >= s + l + 10) ? StRun : StHold;
      chk_st("sr", st);
    end
    chk("sr.lc", loss_count, Stats);

    // Lock loss in HOLD takes priority over the pending request.
    s2 = t + 2;
    go(s2); soft_reset_req = 1'b1;
    go(s2 + 3); chk_st("lh.hold", StHold);
    go(s2 + 4); pll_locked = 1'b0;
    go(s2 + 6); chk_st("lh.hold_end", StHold);
    go(s2 + 7); chk_st("lh.pllrst", StPll);
    chk("lh.lc", loss_count, Stats * 2);
    soft_reset_req = 1'b0;
    go(s2 + 11); chk_st("lh.wait", StWait);
    pll_locked = 1'b1;
    go(s2 + 14); chk_st("lh.settle", StSet);
    go(s2 + 23); chk_st("lh.run", StRun);

    // No lock at all: MAX_RETRIES pulses, then FAULT. Entry also checks the
    // asynchronous mid-operation reset clears the counts.
    do_reset("nl");
    for (int i = 0; i < MaxR; i++) begin
      go(3 + 104 * i);   chk_st("nl.pulse", StPll);
      go(4 + 104 * i);   chk_st("nl.wait", StWait);
      go(103 + 104 * i); chk_st("nl.wait_end", StWait);
      chk("nl.tc_pre", timeout_count, Stats * i);
      go(104 + 104 * i);
      chk_st("nl.timeout", (i == MaxR - 1) ? StFault : StPll);
      chk("nl.tc", timeout_count, Stats * (i + 1));
    end
    pll_locked = 1'b1;
    go(104 * MaxR + 30); chk_st("nl.fault_sticky", StFault);
    chk("nl.tc_end", timeout_count, Stats * MaxR);

    // Reaching RUN clears the retry counter: one timeout, RUN, then a full
    // MAX_RETRIES timeouts are needed for FAULT.
    do_reset("rc");
    go(104); chk_st("rc.timeout", StPll);
    go(108); chk_st("rc.wait", StWait);
    go(110); pll_locked = 1'b1;
    go(113); chk_st("rc.settle", StSet);
    go(122); chk_st("rc.run", StRun);
    go(130); pll_locked = 1'b0;
    go(133); chk_st("rc.loss", StPll);
    chk("rc.lc", loss_count, Stats);
    go(237); chk_st("rc.to1", StPll);
    go(341); chk_st("rc.to2", StPll);
    go(444); chk_st("rc.wait3", StWait);
    go(445); chk_st("rc.fault", StFault);
    chk("rc.tc", timeout_count, Stats * 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
